// File: rtl/display_scan_driver.sv
// Multiplexed 7-segment driver: parity-checked character buffer, digit scan
// and registered segment/anode outputs with a saturating parity-error counter.
module display_scan_driver #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int ERR_CNT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic                        shift_en,
    input  logic [$clog2(N_DIGITS)-1:0] wr_addr,
    input  logic [4:0]                  wr_char,
    input  logic                        wr_par,
    output logic [6:0]                  seg,
    output logic [N_DIGITS-1:0]         an,
    output logic [ERR_CNT_W-1:0]        err_count
);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [4:0] BLANK_CODE = 5'b11111;

    logic [4:0]           code_q [N_DIGITS];
    logic [4:0]           code_d [N_DIGITS];
    logic [N_DIGITS-1:0]  valid_q, valid_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [PRE_W-1:0]     pre_q, pre_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [6:0]           seg_q, seg_d;
    logic [N_DIGITS-1:0]  an_q, an_d;
    logic                 new_valid;
    logic                 bad_accept;
    logic                 addr_ok;
    logic                 tick;

    // Out-of-range addresses only exist when N_DIGITS is not a power of two.
    generate
        if ((1 << IDX_W) == N_DIGITS) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_cmp
            assign addr_ok = (wr_addr < IDX_W'(N_DIGITS));
        end
    endgenerate

    function automatic logic [6:0] glyph(input logic [4:0] code, input logic valid);
        logic [6:0] g;
        g = 7'b0000000;
        if (!valid) begin
            g = 7'b1010111;
        end else begin
            case (code)
                5'd0:    g = 7'b1011011;
                5'd1:    g = 7'b1110111;
                5'd2:    g = 7'b0110011;
                5'd3:    g = 7'b1010100;
                5'd4:    g = 7'b1111011;
                5'd5:    g = 7'b0011100;
                5'd6:    g = 7'b1111110;
                5'd7:    g = 7'b1100111;
                5'd8:    g = 7'b0110111;
                5'd9:    g = 7'b0110000;
                5'd10:   g = 7'b0111100;
                5'd11:   g = 7'b1111011;
                5'd12:   g = 7'b0110111;
                5'd13:   g = 7'b1000111;
                5'd14:   g = 7'b1110000;
                5'd15:   g = 7'b0101010;
                5'd16:   g = 7'b0001110;
                5'd17:   g = 7'b1111001;
                5'd18:   g = 7'b1001110;
                5'd19:   g = 7'b0001111;
                default: g = 7'b0000000;
            endcase
        end
        return g;
    endfunction

    // Buffer update: clear beats shift, shift beats addressed write.
    always_comb begin
        code_d     = code_q;
        valid_d    = valid_q;
        err_d      = err_q;
        new_valid  = ~^{wr_char, wr_par};
        bad_accept = 1'b0;
        if (clear) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                code_d[i] = BLANK_CODE;
            end
            valid_d = '1;
            err_d   = '0;
        end else if (shift_en) begin
            for (int i = N_DIGITS - 1; i > 0; i--) begin
                code_d[i]  = code_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
            code_d[0]  = wr_char;
            valid_d[0] = new_valid;
            bad_accept = ~new_valid;
        end else if (wr_en && addr_ok) begin
            code_d[wr_addr]  = wr_char;
            valid_d[wr_addr] = new_valid;
            bad_accept       = ~new_valid;
        end
        if (bad_accept && (err_q != {ERR_CNT_W{1'b1}})) begin
            err_d = err_q + 1'b1;
        end
    end

    always_comb begin
        tick  = (pre_q == PRE_W'(SCAN_DIV - 1));
        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        seg_d = '0;
        an_d  = '0;
        if (enable) begin
            seg_d = glyph(code_q[idx_q], valid_q[idx_q]);
            an_d  = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_q;
        end
    end

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    code_q[gi]  <= BLANK_CODE;
                    valid_q[gi] <= 1'b1;
                end else begin
                    code_q[gi]  <= code_d[gi];
                    valid_q[gi] <= valid_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            err_q <= err_d;
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign err_count = err_q;
endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver: directed steps plus random traffic, every
// cycle compared against a queue-based model of the display buffer and scan.
module tb_display_scan_driver;
    localparam int N         = 4;
    localparam int DIV       = 4;
    localparam int EW        = 8;
    localparam int MAXERR    = (1 << EW) - 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable, clear, wr_en, shift_en;
    logic [1:0]     wr_addr;
    logic [4:0]     wr_char;
    logic           wr_par;
    logic [6:0]     seg;
    logic [N-1:0]   an;
    logic [EW-1:0]  err_count;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [4:0] code;
        bit         valid;
    } entry_t;

    entry_t     dbuf[$];
    int         edges;
    int         m_err;
    logic [6:0] gtab [0:19] = '{
        7'b1011011, 7'b1110111, 7'b0110011, 7'b1010100, 7'b1111011,
        7'b0011100, 7'b1111110, 7'b1100111, 7'b0110111, 7'b0110000,
        7'b0111100, 7'b1111011, 7'b0110111, 7'b1000111, 7'b1110000,
        7'b0101010, 7'b0001110, 7'b1111001, 7'b1001110, 7'b0001111};

    display_scan_driver #(.N_DIGITS(N), .SCAN_DIV(DIV), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .wr_en(wr_en), .shift_en(shift_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .wr_par(wr_par), .seg(seg), .an(an),
        .err_count(err_count));

    always #5 clk = ~clk;

    function automatic logic [6:0] m_glyph(entry_t e);
        if (!e.valid) return 7'b1010111;
        if (e.code < 5'd20) return gtab[e.code];
        return 7'b0000000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_blank();
        dbuf.delete();
        for (int i = 0; i < N; i++) dbuf.push_back('{code: 5'b11111, valid: 1'b1});
        edges = 0;
        m_err = 0;
    endtask

    task automatic count_bad(input bit v);
        if (!v && m_err < MAXERR) m_err++;
    endtask

    // One clock: predict outputs from the pre-edge state, apply the buffer
    // operation, then compare seg/an/err_count just after the edge.
    task automatic cycle();
        int         idx;
        logic [6:0] exp_seg;
        logic [N-1:0] exp_an;
        entry_t     ne;
        idx     = (edges / DIV) % N;
        exp_seg = enable ? m_glyph(dbuf[idx]) : 7'b0;
        exp_an  = enable ? N'(1 << idx) : '0;
        ne.code  = wr_char;
        ne.valid = (^{wr_char, wr_par}) == 1'b0;
        @(posedge clk);
        if (clear) begin
            for (int i = 0; i < N; i++) dbuf[i] = '{code: 5'b11111, valid: 1'b1};
            m_err = 0;
        end else if (shift_en) begin
            dbuf.push_front(ne);
            void'(dbuf.pop_back());
            count_bad(ne.valid);
        end else if (wr_en && int'(wr_addr) < N) begin
            dbuf[wr_addr] = ne;
            count_bad(ne.valid);
        end
        edges++;
        #1;
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("an", 32'(an), 32'(exp_an));
        chk("err_count", 32'(err_count), 32'(m_err));
    endtask

    task automatic idle(input int n);
        wr_en = 0; shift_en = 0; clear = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drive(input bit c, input bit s, input bit w, input logic [1:0] a,
                         input logic [4:0] ch, input logic p);
        clear = c; shift_en = s; wr_en = w; wr_addr = a; wr_char = ch; wr_par = p;
        cycle();
        wr_en = 0; shift_en = 0; clear = 0;
    endtask

    initial begin
        rst_n = 0; enable = 1; clear = 0; wr_en = 0; shift_en = 0;
        wr_addr = 0; wr_char = 0; wr_par = 0;
        model_blank();
        @(posedge clk); @(posedge clk); #2;
        chk("rst_seg", 32'(seg), 0);
        chk("rst_an", 32'(an), 0);
        chk("rst_err", 32'(err_count), 0);
        rst_n = 1;

        // Idle scan: first edge shows digit 0, then one digit per DIV clocks.
        cycle();
        chk("first_an", 32'(an), 1);
        idle(5 * N * DIV);

        drive(0, 0, 1, 2'd2, 5'b00001, 1'b1);
        idle(N * DIV + 2);
        chk("good_wr_err", 32'(err_count), 0);

        drive(0, 0, 1, 2'd0, 5'b00001, 1'b0);
        idle(N * DIV + 2);
        chk("bad_wr_err", 32'(err_count), 1);

        for (int c = 0; c < 4; c++) drive(0, 1, 0, 2'd0, 5'(c), ^(5'(c)));
        idle(N * DIV + 2);
        drive(0, 1, 0, 2'd0, 5'd4, 1'b1);
        idle(N * DIV + 2);

        drive(1, 1, 1, 2'd1, 5'd7, 1'b0);
        idle(N * DIV + 2);
        chk("clear_err", 32'(err_count), 0);
        drive(0, 1, 1, 2'd3, 5'd9, 1'b0);
        idle(N * DIV + 2);

        for (int i = 0; i < 300; i++) begin
            logic [4:0] ch;
            ch = 5'($urandom_range(0, 31));
            drive(0, 0, 1, 2'($urandom_range(0, 3)), ch, ~(^ch));
        end
        chk("sat_err", 32'(err_count), MAXERR);
        drive(1, 0, 0, 2'd0, 5'd0, 1'b0);

        idle(DIV + 1);
        enable = 0;
        idle(7);
        chk("dis_an", 32'(an), 0);
        enable = 1;
        idle(3 * DIV);

        for (int i = 0; i < 600; i++) begin
            logic [4:0] ch;
            ch = 5'($urandom_range(0, 31));
            clear    = ($urandom_range(0, 49) == 0);
            shift_en = ($urandom_range(0, 5) == 0);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 2'($urandom_range(0, 3));
            wr_char  = ch;
            wr_par   = ($urandom_range(0, 3) == 0) ? ~(^ch) : ^ch;
            enable   = ($urandom_range(0, 9) != 0);
            cycle();
        end
        enable = 1;
        idle(DIV + 2);

        // Asynchronous reset between edges must clear outputs at once.
        rst_n = 0;
        #1;
        chk("async_seg", 32'(seg), 0);
        chk("async_an", 32'(an), 0);
        chk("async_err", 32'(err_count), 0);
        model_blank();
        @(posedge clk); #2;
        rst_n = 1;
        cycle();
        chk("rerst_an", 32'(an), 1);
        idle(2 * N * DIV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/display_scan_driver.md
Name: display_scan_driver

Overview:
- Parametrised multi-digit 7-segment driver for the character display path.
- Stores N_DIGITS parity-protected character codes in a register buffer; a write port fills the buffer by address or by shift-in.
- Time-multiplexes the digits onto one shared segment bus with one-hot digit enables.
- Per digit, shows the mapped glyph, the parity-error glyph, or blank, and keeps a parity-error counter.

Parameters:
- N_DIGITS, 4: number of multiplexed digits (2..16).
- SCAN_DIV, 1000: clk cycles per digit slot (>=2).
- ERR_CNT_W, 8: width of the saturating parity-error counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = drive display; 0 = blank outputs, scanning continues.
- clear  in  1  synchronous: blank all digits, zero err_count.
- wr_en  in  1  write wr_char into the digit at wr_addr.
- shift_en  in  1  shift buffer up one digit, wr_char enters digit 0.
- wr_addr  in  $clog2(N_DIGITS)  target digit for wr_en.
- wr_char  in  5  character code E1-E5.
- wr_par  in  1  parity bit; even parity over {wr_char, wr_par}.
- seg  out  7  segments A-G, active-high, registered.
- an  out  N_DIGITS  one-hot digit enable, active-high, registered.
- err_count  out  ERR_CNT_W  saturating count of accepted writes that failed parity.

Behaviour:
- Reset (rst_n=0, async):
  - every buffer entry = code 5'b11111 with valid=1 (blank);
  - scan index = 0, prescaler = 0;
  - seg = 0, an = 0, err_count = 0.
- Parity: valid = ~^{wr_char, wr_par}. The valid bit is stored alongside the code in each entry.
- Buffer update priority per cycle: clear > shift_en > wr_en.
  - clear: all entries become blank/valid; err_count = 0; any write in the same cycle is discarded.
  - shift_en: entry[i] <= entry[i-1] for i = N_DIGITS-1..1, entry[0] <= new code; the top entry is lost. If wr_en is also high, wr_en is ignored.
  - wr_en only: entry[wr_addr] <= new code. wr_addr >= N_DIGITS means no write and no counting.
  - err_count increments by 1 on each accepted write or shift with valid=0, and saturates at all-ones.
- Scan:
  - prescaler counts 0..SCAN_DIV-1 and wraps;
  - a tick occurs when prescaler == SCAN_DIV-1;
  - on a tick, the scan index increments and wraps N_DIGITS-1 -> 0.
- Output registers (updated every cycle):
  - an = enable ? (1 << idx) : 0;
  - seg = enable ? glyph(entry[idx]) : 0;
  - a buffer change to the displayed digit appears on seg 1 cycle after the write edge.
- Glyph function:
  - valid=0 -> 7'b1010111 (error glyph), regardless of code;
  - valid=1, codes 0-19:
    - 0-4: 1011011, 1110111, 0110011, 1010100, 1111011
    - 5-9: 0011100, 1111110, 1100111, 0110111, 0110000
    - 10-14: 0111100, 1111011, 0110111, 1000111, 1110000
    - 15-19: 0101010, 0001110, 1111001, 1001110, 0001111
  - valid=1, codes 20-31 -> 7'b0000000.
- Boundaries:
  - enable toggling does not reset the prescaler or idx;
  - reset asserted mid-scan returns outputs to 0 immediately (async);
  - the first non-zero an appears on the first clk edge after rst_n deasserts, if enable=1.

Test Plan:
- Reset, enable=1, no writes -> an cycles 0001, 0010, 0100, 1000, 0001 every SCAN_DIV clk; seg = 0 throughout (blank codes).
- wr_en, wr_addr=2, wr_char=5'b00001, wr_par=1 -> digit 2 slot shows seg = 1110111; err_count stays 0.
- wr_en, wr_addr=0, wr_char=5'b00001, wr_par=0 (parity fail) -> digit 0 shows 1010111; err_count = 1.
- Four shifts of codes 0, 1, 2, 3 (correct parity) -> digits 3..0 show 1011011, 1110111, 0110011, 1010100; a fifth shift drops code 0.
- shift_en, wr_en and clear high in the same cycle -> all digits blank, err_count = 0. Then shift_en and wr_en together -> only the shift occurs.
- 300 bad-parity writes with ERR_CNT_W=8 -> err_count holds 255.
- enable=0 mid-scan -> an = 0, seg = 0; after re-enable, idx continues from its current value without restarting.
